// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;
    typedef enum logic [1:0] {R_NONE, R_CORE, R_DBG} resp_e;
    localparam int MAX_WAIT_DEF = 4;
    localparam int WAIT_W = 4;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core/debug arbiter in front of a single-port synchronous data memory.
// Core has priority; debug wins after MAX_WAIT consecutive lost cycles or while dbg_hold is high.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int BE_W     = DATA_W / 8,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [BE_W-1:0]   core_be,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic [BE_W-1:0]   dbg_be,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              dbg_hold,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_q, wait_d;
    resp_e             resp_q, resp_d;
    logic              dbg_win, core_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
            resp_q <= R_NONE;
        end else begin
            wait_q <= wait_d;
            resp_q <= resp_d;
        end
    end

    // Grants are combinational on the live requests, so they are gated by rst_n to stay quiet in reset.
    always_comb begin
        dbg_win     = rst_n && dbg_req && (!core_req || dbg_hold || wait_q == WAIT_MAX);
        core_win    = rst_n && !dbg_win && core_req && !dbg_hold;
        core_gnt    = core_win;
        dbg_gnt     = dbg_win;
        mem_en      = dbg_win || core_win;
        mem_we      = dbg_win ? dbg_we    : core_win && core_we;
        mem_addr    = dbg_win ? dbg_addr  : core_win ? core_addr  : '0;
        mem_wdata   = dbg_win ? dbg_wdata : core_win ? core_wdata : '0;
        mem_be      = dbg_win ? dbg_be    : core_win ? core_be    : '0;
        wait_d      = (dbg_req && !dbg_win) ? ((wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1) : '0;
        resp_d      = (core_win && !core_we) ? R_CORE : (dbg_win && !dbg_we) ? R_DBG : R_NONE;
        core_rvalid = resp_q == R_CORE;
        dbg_rvalid  = resp_q == R_DBG;
        core_rdata  = core_rvalid ? mem_rdata : '0;
        dbg_rdata   = dbg_rvalid  ? mem_rdata : '0;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus against a reference model of arbitration, memory and responses.
module tb_dmem_arbiter;
    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we, dbg_req, dbg_we, dbg_hold;
    logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
    logic [3:0]  core_be, dbg_be;
    logic        core_gnt, core_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] core_rdata, dbg_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .BE_W(4), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_be(core_be), .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_be(dbg_be), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dbg_hold(dbg_hold),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    // Environment memory answering the DUT's mem_* port.
    logic [31:0] bmem [64];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) bmem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= bmem[mem_addr[7:2]];
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    endtask

    // Reference model: priority rules, an independent memory image and one pending response.
    logic [31:0] ref_mem [64];
    int          mw = 0;
    bit          pc = 0, pd = 0;
    logic [31:0] pcd = '0, pdd = '0;

    always @(negedge clk) begin
        bit cw, dw, ew;
        logic [31:0] ea, ed;
        logic [3:0]  eb;
        if (!rst_n) begin
            chk("rst core_gnt", {31'b0, core_gnt}, 0);
            chk("rst dbg_gnt", {31'b0, dbg_gnt}, 0);
            chk("rst mem", {mem_en, mem_we, mem_be, mem_addr[25:0]} | mem_wdata, 0);
            chk("rst rvalid", {30'b0, core_rvalid, dbg_rvalid}, 0);
            chk("rst rdata", core_rdata | dbg_rdata, 0);
            mw = 0; pc = 0; pd = 0;
        end else begin
            dw = dbg_req && (!core_req || dbg_hold || mw == MW);
            cw = !dw && core_req && !dbg_hold;
            ew = dw ? dbg_we : (cw && core_we);
            ea = dw ? dbg_addr : cw ? core_addr : 0;
            ed = dw ? dbg_wdata : cw ? core_wdata : 0;
            eb = dw ? dbg_be : cw ? core_be : 0;
            chk("core_gnt", {31'b0, core_gnt}, {31'b0, cw});
            chk("dbg_gnt", {31'b0, dbg_gnt}, {31'b0, dw});
            chk("mem_en", {31'b0, mem_en}, {31'b0, cw | dw});
            chk("mem_we", {31'b0, mem_we}, {31'b0, ew});
            chk("mem_addr", mem_addr, ea);
            chk("mem_wdata", mem_wdata, ed);
            chk("mem_be", {28'b0, mem_be}, {28'b0, eb});
            chk("core_rvalid", {31'b0, core_rvalid}, {31'b0, pc});
            chk("core_rdata", core_rdata, pc ? pcd : 0);
            chk("dbg_rvalid", {31'b0, dbg_rvalid}, {31'b0, pd});
            chk("dbg_rdata", dbg_rdata, pd ? pdd : 0);
            pc  = cw && !core_we;
            pd  = dw && !dbg_we;
            pcd = ref_mem[core_addr[7:2]];
            pdd = ref_mem[dbg_addr[7:2]];
            if ((cw || dw) && ew)
                for (int b = 0; b < 4; b++)
                    if (eb[b]) ref_mem[ea[7:2]][8*b +: 8] = ed[8*b +: 8];
            mw = (dbg_req && !dw) ? ((mw == MW) ? MW : mw + 1) : 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0; core_be = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_be = 0; dbg_hold = 0;
    endtask

    task automatic core(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        core_req = 1; core_we = we; core_addr = a; core_wdata = d; core_be = be;
    endtask

    task automatic dbg(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_be = be;
    endtask

    initial begin
        logic [5:0] cg, dg;
        for (int i = 0; i < 64; i++) begin
            bmem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        bmem[0] = 32'h11111111; ref_mem[0] = 32'h11111111;
        bmem[1] = 32'h22222222; ref_mem[1] = 32'h22222222;
        bmem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        bmem[8] = 32'h55555555; ref_mem[8] = 32'h55555555;
        mem_rdata = 0;
        idle();
        rst_n = 0;
        core(0, 32'h10, 0, 4'hF);
        look();
        chk("lit rst core_gnt", {31'b0, core_gnt}, 0);
        tick();
        rst_n = 1;
        look();
        chk("lit release core_gnt", {31'b0, core_gnt}, 1);
        tick();
        idle();
        look();
        chk("lit load core_rvalid", {31'b0, core_rvalid}, 1);
        chk("lit load core_rdata", core_rdata, 32'hDEADBEEF);
        chk("lit load dbg_rvalid", {31'b0, dbg_rvalid}, 0);
        tick();
        core(0, 32'h0, 0, 4'hF);
        dbg(0, 32'h4, 0, 4'hF);
        for (int i = 0; i < 6; i++) begin
            look();
            cg[i] = core_gnt;
            dg[i] = dbg_gnt;
            tick();
        end
        chk("lit contention core", {26'b0, cg}, 32'b101111);
        chk("lit contention dbg", {26'b0, dg}, 32'b010000);
        idle();
        dbg_hold = 1;
        core(0, 32'h0, 0, 4'hF);
        dbg(1, 32'h20, 32'h000000AA, 4'b0001);
        look();
        chk("lit hold dbg_gnt", {31'b0, dbg_gnt}, 1);
        chk("lit hold mem_we", {31'b0, mem_we}, 1);
        chk("lit hold mem_be", {28'b0, mem_be}, 32'b0001);
        chk("lit hold core_gnt", {31'b0, core_gnt}, 0);
        tick();
        dbg_req = 0;
        for (int i = 0; i < 3; i++) begin
            look();
            chk("lit hold stall", {30'b0, core_gnt, mem_en}, 0);
            tick();
        end
        dbg_hold = 0;
        tick();
        idle();
        dbg(0, 32'h20, 0, 4'hF);
        tick();
        idle();
        look();
        chk("lit byte write readback", dbg_rdata, 32'h555555AA);
        tick();
        core(0, 32'h0, 0, 4'hF);
        tick();
        idle();
        dbg(0, 32'h4, 0, 4'hF);
        look();
        chk("lit alt core_rvalid", {30'b0, core_rvalid, dbg_rvalid}, 32'b10);
        chk("lit alt core_rdata", core_rdata, 32'h11111111);
        tick();
        idle();
        core(1, 32'h8, 32'hCAFEF00D, 4'hF);
        look();
        chk("lit alt dbg_rvalid", {30'b0, core_rvalid, dbg_rvalid}, 32'b01);
        chk("lit alt dbg_rdata", dbg_rdata, 32'h22222222);
        chk("lit write gnt with rvalid", {31'b0, core_gnt}, 1);
        tick();
        idle();
        core(0, 32'h10, 0, 4'hF);
        look();
        rst_n = 0;
        tick();
        idle();
        tick();
        rst_n = 1;
        for (int i = 0; i < 2; i++) begin
            look();
            chk("lit reset drops load", {31'b0, core_rvalid}, 0);
            tick();
        end
        for (int i = 0; i < 60; i++) begin
            core_req = 1'($urandom_range(0, 1)); core_we = 1'($urandom_range(0, 1));
            core_addr = {24'b0, 6'($urandom_range(0, 15)), 2'b0}; core_wdata = $urandom; core_be = 4'($urandom);
            dbg_req = 1'($urandom_range(0, 1)); dbg_we = 1'($urandom_range(0, 1));
            dbg_addr = {24'b0, 6'($urandom_range(0, 15)), 2'b0}; dbg_wdata = $urandom; dbg_be = 4'($urandom);
            dbg_hold = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle();
        tick();
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
